// File: rtl/fault_detect_monitor.sv
// rtl/fault_detect_monitor.sv - fault-injection response checker; optional mismatch history via FDM_HISTORY_EN
module fault_detect_monitor #(
   parameter int IDX_W      = 4,
   parameter int CNT_W      = 5,
   parameter int HIST_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   input  logic [IDX_W-1:0] vec_idx,
   input  logic             vec_last,
   input  logic             y_golden,
   input  logic             y_faulty,
   output logic             busy,
   output logic             done,
   output logic             detected,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic             first_valid,
   output logic [IDX_W-1:0] first_idx
`ifdef FDM_HISTORY_EN
   ,
   input  logic             hist_rd,
   output logic [IDX_W-1:0] hist_idx,
   output logic             hist_empty,
   output logic             hist_ovf
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             det_q, det_d;
   logic             fv_q, fv_d;
   logic [IDX_W-1:0] fidx_q, fidx_d;

   logic launch;
   logic accept;
   logic mism;

   // A start pulse only launches a campaign outside RUN; the start cycle
   // itself is never in RUN, so its sample can never be accepted.
   assign launch = start && (state_q != S_RUN);
   assign accept = (state_q == S_RUN) && vec_valid;
   assign mism   = accept && (y_golden !== y_faulty);

   // Campaign sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (vec_valid && vec_last) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Result next-state: cleared on launch, updated on every mismatch
   always_comb begin
      cnt_d  = cnt_q;
      det_d  = det_q;
      fv_d   = fv_q;
      fidx_d = fidx_q;
      if (launch) begin
         cnt_d  = '0;
         det_d  = 1'b0;
         fv_d   = 1'b0;
         fidx_d = '0;
      end else if (mism) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         det_d = 1'b1;
         if (!fv_q) begin
            fv_d   = 1'b1;
            fidx_d = vec_idx;
         end
      end
   end

   // Result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         det_q  <= 1'b0;
         fv_q   <= 1'b0;
         fidx_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         det_q  <= det_d;
         fv_q   <= fv_d;
         fidx_q <= fidx_d;
      end
   end

   assign busy         = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);
   assign detected     = det_q;
   assign mismatch_cnt = cnt_q;
   assign first_valid  = fv_q;
   assign first_idx    = fidx_q;

`ifdef FDM_HISTORY_EN
   localparam int PTR_W = $clog2(HIST_DEPTH);

   logic [IDX_W-1:0] hmem_q [HIST_DEPTH];
   logic [PTR_W:0]   wr_q, rd_q;
   logic             ovf_q;
   logic             h_full, h_empty, h_pop, h_push_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign h_empty   = (wr_q == rd_q);
   assign h_full    = ((wr_q - rd_q) == (PTR_W+1)'(HIST_DEPTH));
   assign h_pop     = hist_rd && !h_empty;
   assign h_push_ok = mism && (!h_full || h_pop);

   // History pointers and overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else if (launch) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (h_push_ok) wr_q <= wr_q + (PTR_W+1)'(1);
         if (h_pop)     rd_q <= rd_q + (PTR_W+1)'(1);
         if (mism && h_full && !h_pop) ovf_q <= 1'b1;
      end
   end

   // History storage; entries are only observed through the empty gate
   always_ff @(posedge clk) begin
      if (h_push_ok && !launch) hmem_q[wr_q[PTR_W-1:0]] <= vec_idx;
   end

   assign hist_idx   = h_empty ? '0 : hmem_q[rd_q[PTR_W-1:0]];
   assign hist_empty = h_empty;
   assign hist_ovf   = ovf_q;
`endif

endmodule

// File: doc/fault_detect_monitor.md
# fault_detect_monitor

Downstream response checker for the fault-injection validation flow. Each cycle it samples the golden and fault-injected outputs of the circuit under test, along with the index of the applied input vector, over one test campaign. It counts mismatches, latches the first detecting vector and reports whether the injected fault was detected. A campaign is bracketed by a `start` pulse and a `vec_last` marker from the stimulus side.

## Interface
Parameters:
- `IDX_W`, 4, width of input-vector index (4 inputs → 16 vectors)
- `CNT_W`, 5, width of mismatch counter (saturating)
- `HIST_DEPTH`, 4, mismatch-history FIFO depth, power of two (only with `FDM_HISTORY_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a new campaign
- `vec_valid`  in  1  current `vec_idx`/`y_golden`/`y_faulty` are valid
- `vec_idx`  in  IDX_W  index of applied input vector
- `vec_last`  in  1  qualifies the final vector of the campaign (with `vec_valid`)
- `y_golden`  in  1  fault-free circuit output
- `y_faulty`  in  1  fault-injected circuit output
- `busy`  out  1  campaign in progress
- `done`  out  1  campaign complete; results stable
- `detected`  out  1  at least one mismatch seen this campaign
- `mismatch_cnt`  out  CNT_W  mismatches this campaign, saturating
- `first_valid`  out  1  `first_idx` holds a captured value
- `first_idx`  out  IDX_W  `vec_idx` of the first mismatch
- `hist_rd`  in  1  pop history head (`FDM_HISTORY_EN` only)
- `hist_idx`  out  IDX_W  history head, fall-through; 0 when empty (`FDM_HISTORY_EN` only)
- `hist_empty`  out  1  history empty (`FDM_HISTORY_EN` only)
- `hist_ovf`  out  1  sticky; a mismatch was dropped because history was full (`FDM_HISTORY_EN` only)

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free; outputs derive from registers only.
- IDLE → RUN on `start`. DONE → RUN on `start`. RUN → DONE on accepted `vec_valid & vec_last`.
- `start` while in RUN is ignored. A campaign cannot be restarted mid-run except by `rst`.
- On the `start` edge, clear `mismatch_cnt`, `detected`, `first_valid`, `first_idx`, and the history FIFO and `hist_ovf`.
- Sample acceptance: in RUN only. A sample is accepted when `vec_valid`=1 and the current cycle is not the `start` cycle. `vec_valid` in IDLE or DONE is ignored.
- Mismatch: an accepted sample with `y_golden != y_faulty`. X/Z on either input counts as a mismatch (compare with `!==`).
- On a mismatch:
  - `mismatch_cnt` increments, holding at 2^CNT_W−1.
  - `detected` is set.
  - If `first_valid`=0, capture `first_idx`=`vec_idx` and set `first_valid`.
- The final sample (`vec_last`) is compared like any other before DONE is entered.
- `busy`=1 in RUN. `done`=1 in DONE (level, held until the next `start` or `rst`).
- `vec_idx` order is not checked. Duplicate indices are counted each time.

## Timing
- Reset values: all outputs 0; `hist_empty`=1; state IDLE.
- `rst` asserted at any time (including mid-campaign) returns to IDLE immediately and clears all results.
- `busy` rises one cycle after the `start` edge.
- Result registers update on the clock edge that samples a mismatch, so they are visible the next cycle (1-cycle latency).
- `done` rises and `busy` falls one cycle after the `vec_last` sample. The counters already include that sample at that point.
- `start` and `vec_valid & vec_last` in the same RUN cycle: the sample is accepted, state goes to DONE, and `start` is ignored.

## Configuration
- `FDM_HISTORY_EN` defined: include a HIST_DEPTH-entry FIFO of mismatching `vec_idx` values.
  - Push on every mismatch.
  - When full, the new entry is dropped and `hist_ovf` is set. Simultaneous push and pop when full: both occur.
  - `hist_rd` pops the head when not empty, in any state. A pop when empty is ignored.
  - The history ports exist only with the macro.
- Undefined: no FIFO and no history ports. Core behaviour is identical.

## Test plan
- Reset mid-campaign: `start`, 3 samples with 2 mismatches, then `rst` → all outputs 0, `hist_empty`=1, IDLE, and a subsequent `vec_valid` is ignored.
- Exhaustive clean campaign: `start`, then idx 0..15 with `y_golden`=`y_faulty`, `vec_last` on 15 → `done`=1 one cycle after idx 15, `detected`=0, `mismatch_cnt`=0, `first_valid`=0.
- Detection: idx 0..15 with mismatches at 5, 9 and 15 (15 flagged `vec_last`) → `mismatch_cnt`=3, `first_idx`=5, `detected`=1. A `start` on the idx 15 cycle is ignored.
- Saturation (CNT_W=3): 10 mismatching samples → `mismatch_cnt`=7. A following `start` → `mismatch_cnt`=0, `busy`=1, and `vec_valid` on the `start` cycle is not counted.
- History (`FDM_HISTORY_EN`, depth 4): mismatches at idx 2, 3, 7, 8, 11 → FIFO holds 2, 3, 7, 8 and `hist_ovf`=1. Four `hist_rd` pops read 2, 3, 7, 8, then `hist_empty`=1 and `hist_idx`=0.
